// File: rtl/core_multicycle.sv
// RV32I multicycle core: FETCH/DECODE/EXECUTE/MEM/WB sequencer over
// separate instruction and data word ports with ready handshakes.
module core_multicycle #(
    parameter int          SIZE       = 32,
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    output logic                  ROM_REQ,
    output logic [ADDR_WIDTH-1:0] ADDR_ROM,
    input  logic                  ROM_READY,
    input  logic [SIZE-1:0]       Q_ROM,
    output logic                  RAM_REQ,
    output logic                  ENABLE_W,
    output logic [ADDR_WIDTH-1:0] ADDR_RAM,
    output logic [SIZE-1:0]       Q_W,
    input  logic [SIZE-1:0]       Q_RAM,
    input  logic                  RAM_READY,
    output logic                  INSTRET,
    output logic                  HALTED
);
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_JAL = 7'b1101111, OP_JALR  = 7'b1100111,
                           OP_BR  = 7'b1100011, OP_LOAD  = 7'b0000011,
                           OP_ST  = 7'b0100011, OP_IMM   = 7'b0010011,
                           OP_REG = 7'b0110011;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   pc_q, ir_q, a_q, b_q, imm_q, alu_q, npc_q, mdr_q;
    logic [SIZE-1:0]   rf_q [0:31];

    logic [6:0] opc;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    logic       is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_imm, is_op;
    logic       legal, wr_en;

    assign opc      = ir_q[6:0];
    assign f3       = ir_q[14:12];
    assign rd       = ir_q[11:7];
    assign rs1      = ir_q[19:15];
    assign rs2      = ir_q[24:20];
    assign is_lui   = opc == OP_LUI;
    assign is_auipc = opc == OP_AUIPC;
    assign is_jal   = opc == OP_JAL;
    assign is_jalr  = opc == OP_JALR;
    assign is_br    = opc == OP_BR;
    assign is_ld    = opc == OP_LOAD;
    assign is_st    = opc == OP_ST;
    assign is_imm   = opc == OP_IMM;
    assign is_op    = opc == OP_REG;
    assign wr_en    = is_lui | is_auipc | is_jal | is_jalr | is_ld | is_imm | is_op;

    // ECALL/EBREAK fall out as illegal, which halts the same way.
    assign legal = is_lui | is_auipc | is_jal | is_imm | is_op
                 | (is_jalr && f3 == 3'b000)
                 | (is_br && f3 != 3'b010 && f3 != 3'b011)
                 | ((is_ld | is_st) && f3 == 3'b010);

    logic [SIZE-1:0] rs1_val, rs2_val, imm_c;
    assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

    always_comb begin
        imm_c = {{20{ir_q[31]}}, ir_q[31:20]};
        if (is_st)                imm_c = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        else if (is_br)           imm_c = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
        else if (is_lui|is_auipc) imm_c = {ir_q[31:12], 12'b0};
        else if (is_jal)          imm_c = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    end

    logic [SIZE-1:0] op_a, op_b, alu_c, tgt, npc_c, pc4;
    logic            cond, take, misalign;

    assign op_a = is_auipc ? pc_q : (is_lui ? '0 : a_q);
    assign op_b = (is_op | is_br) ? b_q : imm_q;
    assign pc4  = pc_q + 32'd4;

    always_comb begin
        alu_c = op_a + op_b;
        if (is_op | is_imm) begin
            case (f3)
                3'b000: alu_c = (is_op && ir_q[30]) ? op_a - op_b : op_a + op_b;
                3'b001: alu_c = op_a << op_b[4:0];
                3'b010: alu_c = {{(SIZE-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                3'b011: alu_c = {{(SIZE-1){1'b0}}, op_a < op_b};
                3'b100: alu_c = op_a ^ op_b;
                3'b101: alu_c = ir_q[30] ? SIZE'($signed(op_a) >>> op_b[4:0]) : op_a >> op_b[4:0];
                3'b110: alu_c = op_a | op_b;
                default: alu_c = op_a & op_b;
            endcase
        end
    end

    always_comb begin
        case (f3)
            3'b000:  cond = a_q == b_q;
            3'b001:  cond = a_q != b_q;
            3'b100:  cond = $signed(a_q) < $signed(b_q);
            3'b101:  cond = $signed(a_q) >= $signed(b_q);
            3'b110:  cond = a_q < b_q;
            default: cond = a_q >= b_q;
        endcase
    end

    assign tgt      = is_jalr ? ((a_q + imm_q) & ~32'd1) : pc_q + imm_q;
    assign take     = is_jal | is_jalr | (is_br & cond);
    assign npc_c    = take ? tgt : pc4;
    assign misalign = take & tgt[1];

    always_ff @(posedge CLK) begin
        if (!RESET_N) state_q <= FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (ROM_READY) state_d = DECODE;
            DECODE:  state_d = legal ? EXECUTE : HALT;
            EXECUTE: state_d = misalign ? HALT : ((is_ld | is_st) ? MEM : WB);
            MEM:     if (RAM_READY) state_d = WB;
            WB:      state_d = FETCH;
            default: state_d = HALT;
        endcase
    end

    // Strobes are masked by RESET_N so nothing leaks out while reset is held.
    assign ROM_REQ  = RESET_N && state_q == FETCH;
    assign RAM_REQ  = RESET_N && state_q == MEM;
    assign ENABLE_W = RESET_N && state_q == MEM && is_st;
    assign INSTRET  = RESET_N && state_q == WB;
    assign HALTED   = RESET_N && state_q == HALT;
    assign ADDR_ROM = pc_q[ADDR_WIDTH+1:2];
    assign ADDR_RAM = RESET_N ? alu_q[ADDR_WIDTH+1:2] : '0;
    assign Q_W      = RESET_N ? b_q : '0;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            pc_q  <= RESET_PC;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            imm_q <= '0;
            alu_q <= '0;
            npc_q <= '0;
            mdr_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                FETCH:   if (ROM_READY) ir_q <= Q_ROM;
                DECODE:  begin
                    a_q   <= rs1_val;
                    b_q   <= rs2_val;
                    imm_q <= imm_c;
                end
                EXECUTE: begin
                    alu_q <= alu_c;
                    npc_q <= npc_c;
                end
                MEM:     if (RAM_READY && is_ld) mdr_q <= Q_RAM;
                WB:      begin
                    pc_q <= npc_q;
                    if (wr_en && rd != 5'd0)
                        rf_q[rd] <= (is_jal | is_jalr) ? pc4 : (is_ld ? mdr_q : alu_q);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_core_multicycle.sv
// Scoreboard bench for core_multicycle: stimulus queues expected bus
// events, a negedge monitor matches what the core actually presents.
module tb_core_multicycle;
    localparam int AW = 10;
    localparam logic [6:0] LUI = 7'b0110111, JAL = 7'b1101111, JALR = 7'b1100111,
                           BR = 7'b1100011, LD = 7'b0000011, ST = 7'b0100011,
                           IMM = 7'b0010011, OPR = 7'b0110011;

    logic          CLK, RESET_N;
    logic          ROM_REQ, ROM_READY, RAM_REQ, ENABLE_W, RAM_READY, INSTRET, HALTED;
    logic [AW-1:0] ADDR_ROM, ADDR_RAM;
    logic [31:0]   Q_ROM, Q_W, Q_RAM;

    core_multicycle #(.SIZE(32), .ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ROM_REQ(ROM_REQ), .ADDR_ROM(ADDR_ROM),
        .ROM_READY(ROM_READY), .Q_ROM(Q_ROM), .RAM_REQ(RAM_REQ), .ENABLE_W(ENABLE_W),
        .ADDR_RAM(ADDR_RAM), .Q_W(Q_W), .Q_RAM(Q_RAM), .RAM_READY(RAM_READY),
        .INSTRET(INSTRET), .HALTED(HALTED));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [31:0] rom [0:63];
    logic [31:0] ram [0:15];
    int rom_wait, ram_delay, rom_cnt, ram_cnt;
    bit ram_en;

    // A zero wait/delay keeps READY high permanently, including outside FETCH/MEM.
    assign ROM_READY = (rom_wait == 0) || (ROM_REQ && rom_cnt == rom_wait);
    assign RAM_READY = ram_en && ((ram_delay == 0) || (RAM_REQ && ram_cnt == ram_delay));
    assign Q_ROM     = rom[ADDR_ROM[5:0]];
    assign Q_RAM     = ram[ADDR_RAM[3:0]];

    always @(posedge CLK) begin
        rom_cnt <= (ROM_REQ && !ROM_READY) ? rom_cnt + 1 : 0;
        ram_cnt <= (RAM_REQ && !RAM_READY) ? ram_cnt + 1 : 0;
        if (RAM_REQ && RAM_READY && ENABLE_W) ram[ADDR_RAM[3:0]] <= Q_W;
    end

    typedef struct { int kind; logic [31:0] a; logic [31:0] b; logic c; } ev_t;
    ev_t sbq [$];
    int checks = 0, failures = 0, cyc = 0, overlap = 0, ecyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] b, input logic c);
        ev_t e;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL unexpected event kind=%0d a=0x%08h b=0x%08h c=%0b at cyc %0d", kind, a, b, c, cyc);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind || e.a !== a || e.c !== c || (kind == 1 && c && e.b !== b)) begin
                failures++;
                $display("FAIL event at cyc %0d: got kind=%0d a=0x%08h b=0x%08h c=%0b expected kind=%0d a=0x%08h b=0x%08h c=%0b",
                         cyc, kind, a, b, c, e.kind, e.a, e.b, e.c);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET_N) cyc = 0;
        else begin
            cyc++;
            if (ROM_REQ && RAM_REQ) overlap++;
            if (ROM_REQ && ROM_READY) observe(0, 32'(ADDR_ROM), 32'h0, 1'b0);
            if (RAM_REQ && RAM_READY) observe(1, 32'(ADDR_RAM), Q_W, ENABLE_W);
            if (INSTRET) observe(2, cyc, 32'h0, 1'b0);
        end
    end

    task automatic push_fetch(input int pc);
        sbq.push_back('{0, 32'(pc >> 2), 32'h0, 1'b0});
    endtask

    // Retire cycle = 4 + ROM waits, plus 1 + RAM waits for loads/stores.
    task automatic push_instr(input int pc, input bit mem, input bit we, input int addr, input logic [31:0] wd);
        push_fetch(pc);
        ecyc += 4 + rom_wait + (mem ? 1 + ram_delay : 0);
        if (mem) sbq.push_back('{1, 32'(addr), wd, we});
        sbq.push_back('{2, 32'(ecyc), 32'h0, 1'b0});
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] r1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {im, r1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] r2, input logic [4:0] r1);
        return {im[11:5], r2, r1, 3'b010, im[4:0], ST};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] r2, input logic [4:0] r1, input logic [2:0] f3);
        return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], BR};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd, JAL};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, r2, r1, f3, rd, OPR};
    endfunction

    task automatic wait_halt(input int budget, input string name);
        for (int i = 0; i < budget && !HALTED; i++) @(negedge CLK);
        chk(name, 32'(HALTED), 32'h1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ROM_REQ"}, 32'(ROM_REQ), 32'h0);
        chk({tag, " RAM_REQ"}, 32'(RAM_REQ), 32'h0);
        chk({tag, " ENABLE_W"}, 32'(ENABLE_W), 32'h0);
        chk({tag, " INSTRET"}, 32'(INSTRET), 32'h0);
        chk({tag, " ADDR_RAM"}, 32'(ADDR_RAM), 32'h0);
        chk({tag, " Q_W"}, Q_W, 32'h0);
        chk({tag, " HALTED"}, 32'(HALTED), 32'h0);
    endtask

    initial begin
        int n;
        RESET_N = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        for (int i = 0; i < 16; i++) ram[i] = 32'h0;
        rom_wait = 0; ram_delay = 3; ram_en = 1'b1;

        // Phase 1: arithmetic, load/store with RAM waits, branches, jumps, misaligned halt.
        rom[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, IMM);
        rom[1]  = enc_i(12'hFF9, 5'd1, 3'b000, 5'd2, IMM);
        rom[2]  = enc_s(12'd8, 5'd2, 5'd0);
        rom[3]  = enc_i(12'd8, 5'd0, 3'b010, 5'd3, LD);
        rom[4]  = enc_s(12'd12, 5'd3, 5'd0);
        rom[5]  = enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, IMM);
        rom[6]  = enc_i(12'd1, 5'd0, 3'b000, 5'd2, IMM);
        rom[7]  = enc_b(13'd12, 5'd2, 5'd1, 3'b100);
        rom[8]  = enc_i(12'd1, 5'd0, 3'b000, 5'd7, IMM);
        rom[9]  = enc_i(12'd1, 5'd0, 3'b000, 5'd7, IMM);
        rom[10] = enc_b(13'd12, 5'd2, 5'd1, 3'b110);
        rom[11] = enc_j(21'd16, 5'd1);
        rom[12] = enc_s(12'd16, 5'd1, 5'd0);
        rom[13] = {20'h80000, 5'd5, LUI};
        rom[14] = enc_j(21'd8, 5'd0);
        rom[15] = enc_i(12'd0, 5'd1, 3'b000, 5'd0, JALR);
        rom[16] = enc_i(12'h404, 5'd5, 3'b101, 5'd6, IMM);
        rom[17] = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd7);
        rom[18] = enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd8);
        rom[19] = enc_i(12'hFFF, 5'd6, 3'b100, 5'd9, IMM);
        rom[20] = enc_s(12'd20, 5'd6, 5'd0);
        rom[21] = enc_s(12'd24, 5'd7, 5'd0);
        rom[22] = enc_s(12'd28, 5'd8, 5'd0);
        rom[23] = enc_s(12'd32, 5'd9, 5'd0);
        rom[24] = enc_i(12'd7, 5'd0, 3'b000, 5'd0, IMM);
        rom[25] = enc_s(12'd36, 5'd0, 5'd0);
        rom[26] = enc_j(21'd2, 5'd0);

        ecyc = 0;
        push_instr(32'h00, 0, 0, 0, 32'h0);
        push_instr(32'h04, 0, 0, 0, 32'h0);
        push_instr(32'h08, 1, 1, 2, 32'hFFFFFFFE);
        push_instr(32'h0C, 1, 0, 2, 32'h0);
        push_instr(32'h10, 1, 1, 3, 32'hFFFFFFFE);
        push_instr(32'h14, 0, 0, 0, 32'h0);
        push_instr(32'h18, 0, 0, 0, 32'h0);
        push_instr(32'h1C, 0, 0, 0, 32'h0);
        push_instr(32'h28, 0, 0, 0, 32'h0);
        push_instr(32'h2C, 0, 0, 0, 32'h0);
        push_instr(32'h3C, 0, 0, 0, 32'h0);
        push_instr(32'h30, 1, 1, 4, 32'h00000030);
        push_instr(32'h34, 0, 0, 0, 32'h0);
        push_instr(32'h38, 0, 0, 0, 32'h0);
        push_instr(32'h40, 0, 0, 0, 32'h0);
        push_instr(32'h44, 0, 0, 0, 32'h0);
        push_instr(32'h48, 0, 0, 0, 32'h0);
        push_instr(32'h4C, 0, 0, 0, 32'h0);
        push_instr(32'h50, 1, 1, 5, 32'hF8000000);
        push_instr(32'h54, 1, 1, 6, 32'hFFFFFFD1);
        push_instr(32'h58, 1, 1, 7, 32'h00000001);
        push_instr(32'h5C, 1, 1, 8, 32'h07FFFFFF);
        push_instr(32'h60, 0, 0, 0, 32'h0);
        push_instr(32'h64, 1, 1, 9, 32'h0);
        push_fetch(32'h68);

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_reset_outputs("reset");
        @(posedge CLK); #1 RESET_N = 1'b1;
        @(negedge CLK);
        chk("first ROM_REQ", 32'(ROM_REQ), 32'h1);
        chk("first ADDR_ROM", 32'(ADDR_ROM), 32'h0);
        wait_halt(400, "p1 misaligned JAL halts");
        repeat (3) @(negedge CLK);
        chk("p1 halted ROM_REQ", 32'(ROM_REQ), 32'h0);
        chk("p1 scoreboard drained", sbq.size(), 0);

        // Phase 2: reset while SW sits in MEM with RAM never ready.
        @(posedge CLK); #1 RESET_N = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        rom[0] = enc_i(12'd3, 5'd0, 3'b000, 5'd1, IMM);
        rom[1] = enc_s(12'd0, 5'd1, 5'd0);
        ram_en = 1'b0; rom_wait = 0; ram_delay = 0;
        ecyc = 0;
        push_instr(32'h00, 0, 0, 0, 32'h0);
        push_fetch(32'h04);
        @(posedge CLK); #1 RESET_N = 1'b1;
        n = 0;
        while (!RAM_REQ && n < 20) begin @(negedge CLK); n++; end
        chk("p2 SW reaches MEM", 32'(RAM_REQ), 32'h1);
        chk("p2 Q_W holds rs2", Q_W, 32'h3);
        repeat (2) @(negedge CLK);
        @(posedge CLK); #1 RESET_N = 1'b0;
        @(negedge CLK);
        chk_reset_outputs("abort");
        chk("p2 scoreboard drained", sbq.size(), 0);

        // Phase 3: ROM waits, RAM_READY stuck high, x1 cleared by reset, illegal opcode.
        rom[0] = enc_s(12'd4, 5'd1, 5'd0);
        rom[1] = 32'h0000007F;
        rom_wait = 2; ram_delay = 0; ram_en = 1'b1;
        ecyc = 0;
        push_instr(32'h00, 1, 1, 1, 32'h0);
        push_fetch(32'h04);
        @(posedge CLK); #1 RESET_N = 1'b1;
        @(negedge CLK);
        chk("p3 RAM_REQ after abort", 32'(RAM_REQ), 32'h0);
        chk("p3 restart ADDR_ROM", 32'(ADDR_ROM), 32'h0);
        wait_halt(40, "p3 illegal opcode halts");
        n = 0;
        for (int i = 0; i < 10; i++) begin @(negedge CLK); n += int'(ROM_REQ) + int'(INSTRET); end
        chk("p3 idle while halted", n, 0);
        chk("p3 scoreboard drained", sbq.size(), 0);

        // Phase 4: one-cycle reset pulse out of HALT restarts at RESET_PC.
        ecyc = 0;
        push_instr(32'h00, 1, 1, 1, 32'h0);
        push_fetch(32'h04);
        @(posedge CLK); #1 RESET_N = 1'b0;
        @(negedge CLK);
        chk("p4 HALTED cleared in reset", 32'(HALTED), 32'h0);
        @(posedge CLK); #1 RESET_N = 1'b1;
        @(negedge CLK);
        chk("p4 restart ROM_REQ", 32'(ROM_REQ), 32'h1);
        chk("p4 restart ADDR_ROM", 32'(ADDR_ROM), 32'h0);
        wait_halt(40, "p4 halts again");
        chk("p4 scoreboard drained", sbq.size(), 0);
        chk("ROM_REQ/RAM_REQ overlap cycles", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end
endmodule
